xgmii_link_monitor: RTL

XGMII_LINK_MONITOR -- requirements
Module: xgmii_link_monitor

---
 rtl/xgmii_link_monitor_pkg.sv | 33 +++
 rtl/xgmii_column_decode.sv | 59 +++++
 rtl/xgmii_link_monitor.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/xgmii_link_monitor_pkg.sv
// Shared XGMII constants, link-state encoding and the half-column
// fault-sequence classifier used by the column decoder.
package xgmii_link_monitor_pkg;

   typedef enum logic [7:0] {
      CTRL_IDLE      = 8'h07,
      CTRL_START     = 8'hFB,
      CTRL_TERMINATE = 8'hFD,
      CTRL_ERROR     = 8'hFE,
      CTRL_SEQUENCE  = 8'h9C
   } xgmii_ctrl_e;

   typedef enum logic [7:0] {
      FAULT_LOCAL  = 8'h01,
      FAULT_REMOTE = 8'h02
   } fault_code_e;

   typedef enum logic [1:0] {
      LINK_DOWN         = 2'd0,
      LINK_UP           = 2'd1,
      LINK_LOCAL_FAULT  = 2'd2,
      LINK_REMOTE_FAULT = 2'd3
   } link_state_e;

   // Returns {remote, local} for one 4-lane half of a column.
   function automatic logic [1:0] fault_half(input logic [31:0] d, input logic [3:0] c);
      logic seq_ok;
      seq_ok = c[0] && (c[3:1] == 3'b000) && (d[7:0] == CTRL_SEQUENCE) &&
               (d[15:8] == 8'h00) && (d[23:16] == 8'h00);
      return {seq_ok && (d[31:24] == FAULT_REMOTE), seq_ok && (d[31:24] == FAULT_LOCAL)};
   endfunction

endpackage

// File: rtl/xgmii_column_decode.sv
// One-cycle registered classification of an XGMII column into start,
// error, local-fault and remote-fault flags.
module xgmii_column_decode
   import xgmii_link_monitor_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [63:0] rxd_i,
   input  logic [7:0]  rxc_i,
   output logic        start_pre_o,
   output logic        valid_o,
   output logic        start_o,
   output logic        error_o,
   output logic        lfault_o,
   output logic        rfault_o
);

   logic       start_d, error_d, lfault_d, rfault_d;
   logic [1:0] lo_fault_s, hi_fault_s;
   logic       valid_q, start_q, error_q, lfault_q, rfault_q;

   always_comb begin
      start_d = (rxc_i[0] && (rxd_i[7:0] == CTRL_START)) ||
                (rxc_i[4] && (rxd_i[39:32] == CTRL_START));
      error_d = 1'b0;
      for (int n = 0; n < 8; n++) begin
         error_d = error_d | (rxc_i[n] & (rxd_i[8*n +: 8] == CTRL_ERROR));
      end
      lo_fault_s = fault_half(rxd_i[31:0], rxc_i[3:0]);
      hi_fault_s = fault_half(rxd_i[63:32], rxc_i[7:4]);
      lfault_d   = lo_fault_s[0] | hi_fault_s[0];
      // a local sequence in either half outranks a remote one in the other
      rfault_d   = (lo_fault_s[1] | hi_fault_s[1]) & ~lfault_d;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q  <= 1'b0;
         start_q  <= 1'b0;
         error_q  <= 1'b0;
         lfault_q <= 1'b0;
         rfault_q <= 1'b0;
      end else begin
         valid_q  <= 1'b1;
         start_q  <= start_d;
         error_q  <= error_d;
         lfault_q <= lfault_d;
         rfault_q <= rfault_d;
      end
   end

   assign start_pre_o = start_d;
   assign valid_o     = valid_q;
   assign start_o     = start_q;
   assign error_o     = error_q;
   assign lfault_o    = lfault_q;
   assign rfault_o    = rfault_q;

endmodule

// File: rtl/xgmii_link_monitor.sv
// XGMII receive link monitor: link-state FSM, saturating frame/error
// counters and link/activity LED drivers.
module xgmii_link_monitor
   import xgmii_link_monitor_pkg::*;
#(
   parameter int COUNT_WIDTH  = 32,
   parameter int ACT_STRETCH  = 1562500,
   parameter int FAULT_WINDOW = 128
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [63:0]            xgmii_rxd,
   input  logic [7:0]             xgmii_rxc,
   input  logic                   rx_block_lock,
   input  logic                   sfp_los,
   input  logic                   count_clear,
   output logic [1:0]             link_state,
   output logic                   led_link,
   output logic                   led_act,
   output logic [COUNT_WIDTH-1:0] frame_count,
   output logic [COUNT_WIDTH-1:0] error_count
);

   localparam int WIN_W = $clog2(FAULT_WINDOW + 1);
   localparam int ACT_W = $clog2(ACT_STRETCH + 1);
   localparam logic [WIN_W-1:0]       WIN_LAST   = WIN_W'(FAULT_WINDOW - 1);
   localparam logic [ACT_W-1:0]       ACT_RELOAD = ACT_W'(ACT_STRETCH - 1);
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;

   logic start_pre_s, valid_s, start_s, error_s, lfault_s, rfault_s;
   logic link_bad_s, col_fault_s, win_full_s, hit_same_s;
   logic [2:0] hits_s;

   link_state_e state_q, state_d;
   logic [WIN_W-1:0]       win_q, win_d;
   logic [2:0]             fcnt_q, fcnt_d;
   logic                   ftype_q, ftype_d;
   logic                   los_s1_q, los_s2_q, clear_q;
   logic [COUNT_WIDTH-1:0] frame_q, frame_d, error_q, error_d;
   logic [ACT_W-1:0]       act_q, act_d;
   logic                   led_link_q, led_link_d, led_act_q, led_act_d;

   xgmii_column_decode u_decode (
      .clk_i       (clk),
      .rst_i       (rst),
      .rxd_i       (xgmii_rxd),
      .rxc_i       (xgmii_rxc),
      .start_pre_o (start_pre_s),
      .valid_o     (valid_s),
      .start_o     (start_s),
      .error_o     (error_s),
      .lfault_o    (lfault_s),
      .rfault_o    (rfault_s)
   );

   assign link_bad_s  = ~rx_block_lock | los_s2_q;
   assign col_fault_s = lfault_s | rfault_s;
   assign win_full_s  = (win_q == WIN_LAST);
   // ftype 1 = remote; a fault of the other type restarts the count at one
   assign hit_same_s  = (fcnt_q != 3'd0) && (ftype_q == rfault_s);
   assign hits_s      = hit_same_s ? (fcnt_q + 3'd1) : 3'd1;

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      fcnt_d  = fcnt_q;
      ftype_d = ftype_q;
      if (link_bad_s) begin
         state_d = LINK_DOWN;
         win_d   = '0;
         fcnt_d  = 3'd0;
      end else if (valid_s) begin
         if (col_fault_s || win_full_s) begin
            win_d = '0;
         end else begin
            win_d = win_q + WIN_W'(1);
         end
         case (state_q)
            LINK_DOWN: begin
               fcnt_d = 3'd0;
               if (!col_fault_s && win_full_s) begin
                  state_d = LINK_UP;
               end else begin
                  state_d = LINK_DOWN;
               end
            end
            LINK_UP, LINK_LOCAL_FAULT, LINK_REMOTE_FAULT: begin
               if (col_fault_s) begin
                  ftype_d = rfault_s;
                  if (hits_s == 3'd4) begin
                     fcnt_d  = 3'd0;
                     state_d = rfault_s ? LINK_REMOTE_FAULT : LINK_LOCAL_FAULT;
                  end else begin
                     fcnt_d  = hits_s;
                  end
               end else if (win_full_s) begin
                  fcnt_d  = 3'd0;
                  state_d = LINK_UP;
               end else begin
                  fcnt_d  = fcnt_q;
               end
            end
            default: state_d = LINK_DOWN;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   always_comb begin
      if (clear_q) begin
         frame_d = '0;
         error_d = '0;
      end else begin
         frame_d = (start_s && (frame_q != COUNT_MAX)) ? frame_q + COUNT_WIDTH'(1) : frame_q;
         error_d = (error_s && (error_q != COUNT_MAX)) ? error_q + COUNT_WIDTH'(1) : error_q;
      end
      if (start_s) begin
         act_d = ACT_RELOAD;
      end else if (act_q != '0) begin
         act_d = act_q - ACT_W'(1);
      end else begin
         act_d = act_q;
      end
      led_link_d = (state_d == LINK_UP);
      // start_pre lights the LED as the start column is captured
      led_act_d  = (state_d != LINK_DOWN) && (start_pre_s || start_s || (act_q != '0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= LINK_DOWN;
         win_q      <= '0;
         fcnt_q     <= 3'd0;
         ftype_q    <= 1'b0;
         los_s1_q   <= 1'b0;
         los_s2_q   <= 1'b0;
         clear_q    <= 1'b0;
         frame_q    <= '0;
         error_q    <= '0;
         act_q      <= '0;
         led_link_q <= 1'b0;
         led_act_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         fcnt_q     <= fcnt_d;
         ftype_q    <= ftype_d;
         los_s1_q   <= sfp_los;
         los_s2_q   <= los_s1_q;
         clear_q    <= count_clear;
         frame_q    <= frame_d;
         error_q    <= error_d;
         act_q      <= act_d;
         led_link_q <= led_link_d;
         led_act_q  <= led_act_d;
      end
   end

   assign link_state  = state_q;
   assign led_link    = led_link_q;
   assign led_act     = led_act_q;
   assign frame_count = frame_q;
   assign error_count = error_q;

endmodule
